// File: rtl/instr_mem_loader.sv
// Instruction memory loader: assembles big-endian 32-bit words from a byte
// stream and writes them to consecutive instruction RAM addresses. The core
// is held in reset until a load has completed.
module instr_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              done,
  output logic              cpu_rst
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Largest load is the whole memory, written exactly once.
  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;

  logic              accept;
  logic [ADDR_W:0]   len_clamped;

  assign accept      = (state_q == S_COLLECT) && in_valid;
  assign len_clamped = (load_len > MAX_WORDS) ? MAX_WORDS : load_len;

  // Next-state and datapath updates; start is only honoured when no load runs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d  = load_base;
          rem_d   = len_clamped;
          cnt_d   = 2'd0;
          state_d = (load_len == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          // First byte of a word ends up in the top byte.
          word_d = {word_q[DATA_W-9:0], in_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == (ADDR_W+1)'(1)) ? S_DONE : S_COLLECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    in_ready = (state_q == S_COLLECT);
    mem_we   = (state_q == S_WRITE);
    busy     = (state_q == S_COLLECT) || (state_q == S_WRITE);
    done     = (state_q == S_DONE);
    cpu_rst  = (state_q != S_DONE);
    mem_addr = addr_q;
    mem_din  = word_q;
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a write scoreboard.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  load_base = '0;
  logic [8:0]  load_len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, mem_we, busy, done, cpu_rst;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;

  instr_mem_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .load_base(load_base),
    .load_len(load_len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .busy(busy), .done(done), .cpu_rst(cpu_rst)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int we_cnt = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  bit saw_ready = 0;
  logic [39:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest expected (addr, data).
  always @(negedge clk) begin
    if (in_ready) saw_ready = 1;
    if (!rst && mem_we) begin
      logic [39:0] e;
      we_cnt++;
      last_we_cyc = cyc;
      chk("we_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("mem_addr", mem_addr, e[39:32]);
        chk("mem_din", mem_din, e[31:0]);
      end
      chk("we_not_ready", in_ready, 0);
    end
  end

  task automatic start_load(input logic [7:0] b, input logic [8:0] l);
    start = 1; load_base = b; load_len = l;
    @(negedge clk);
    start = 0;
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      in_valid = 0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1; in_data = b;
    for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
    if (!in_ready) chk("byte_timeout", in_ready, 1);
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int bound);
    for (int i = 0; i < bound && !done; i++) @(negedge clk);
    chk(tag, done, 1);
  endtask

  task automatic push_word(input logic [7:0] a, input logic [31:0] w);
    exp_q.push_back({a, w});
  endtask

  logic [7:0] s1 [8] = '{8'h20, 8'h41, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h10};

  initial begin
    int w0, d;
    logic [31:0] word;
    repeat (3) @(negedge clk);
    rst = 0;
    // Reset state
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);

    // 1: continuous stream
    w0 = we_cnt;
    push_word(8'h00, 32'h20410005);
    push_word(8'h01, 32'h8C220010);
    start_load(8'h00, 9'd2);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 8; i++) send_byte(s1[i], 0);
    in_valid = 0;
    wait_done("t1_done", 10);
    d = cyc - last_we_cyc;
    chk("t1_done_latency", (d >= 1 && d <= 2), 1);
    chk("t1_cpu_rst", cpu_rst, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_we_cnt", we_cnt - w0, 2);

    // 2: same stream with random gaps
    w0 = we_cnt;
    push_word(8'h00, 32'h20410005);
    push_word(8'h01, 32'h8C220010);
    start_load(8'h00, 9'd2);
    chk("t2_done_clear", done, 0);
    chk("t2_cpu_rst", cpu_rst, 1);
    for (int i = 0; i < 8; i++) send_byte(s1[i], $urandom_range(1, 3));
    in_valid = 0;
    wait_done("t2_done", 10);
    repeat (3) @(negedge clk);
    chk("t2_we_cnt", we_cnt - w0, 2);
    chk("t2_queue_empty", exp_q.size(), 0);

    // 3: zero-length load from IDLE
    rst = 1; @(negedge clk); rst = 0;
    chk("t3_idle_cpu_rst", cpu_rst, 1);
    w0 = we_cnt; saw_ready = 0;
    in_valid = 1; in_data = 8'h55;
    start_load(8'h30, 9'd0);
    chk("t3_done", done, 1);
    chk("t3_cpu_rst", cpu_rst, 0);
    repeat (3) @(negedge clk);
    chk("t3_no_we", we_cnt - w0, 0);
    chk("t3_no_ready", saw_ready, 0);
    in_valid = 0;

    // 4: address wrap
    w0 = we_cnt;
    push_word(8'hFE, 32'h11121314);
    push_word(8'hFF, 32'h15161718);
    push_word(8'h00, 32'h191A1B1C);
    start_load(8'hFE, 9'd3);
    for (int i = 0; i < 12; i++) send_byte(8'h11 + 8'(i), 0);
    in_valid = 0;
    wait_done("t4_done", 10);
    chk("t4_we_cnt", we_cnt - w0, 3);

    // 5: reset mid-word, then fresh load
    w0 = we_cnt;
    start_load(8'h10, 9'd2);
    send_byte(8'hE1, 0);
    send_byte(8'hE2, 0);
    rst = 1; in_valid = 0;
    @(negedge clk);
    rst = 0;
    chk("t5_cpu_rst", cpu_rst, 1);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_no_we", we_cnt - w0, 0);
    push_word(8'h10, 32'hAABBCCDD);
    start_load(8'h10, 9'd1);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    in_valid = 0;
    wait_done("t5_reload_done", 10);
    chk("t5_we_cnt", we_cnt - w0, 1);

    // 6a: start during COLLECT is ignored
    w0 = we_cnt;
    push_word(8'h40, 32'h01020304);
    push_word(8'h41, 32'h05060708);
    start_load(8'h40, 9'd2);
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    in_valid = 0;
    start_load(8'h80, 9'd5);
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    for (int i = 5; i <= 8; i++) send_byte(8'(i), 0);
    in_valid = 0;
    wait_done("t6a_done", 10);
    repeat (5) @(negedge clk);
    chk("t6a_we_cnt", we_cnt - w0, 2);
    chk("t6a_still_done", done, 1);

    // 6b: oversized length clamps to the full memory
    w0 = we_cnt;
    start_load(8'h05, 9'd300);
    for (int i = 0; i < 256; i++) begin
      word = $urandom;
      push_word(8'h05 + 8'(i), word);
      for (int b = 0; b < 4; b++) begin
        logic [31:0] tmp;
        tmp = word << (8 * b);
        send_byte(tmp[31:24], 0);
      end
    end
    in_valid = 1; in_data = 8'hEE;
    wait_done("t6b_done", 10);
    repeat (5) @(negedge clk);
    in_valid = 0;
    chk("t6b_we_cnt", we_cnt - w0, 256);
    chk("t6b_queue_empty", exp_q.size(), 0);
    chk("t6b_cpu_rst", cpu_rst, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
